outport_uart_tx: RTL and testbench

Serial transmitter downstream of the processor datapath's output port. Each cycle in which the control unit asserts `OUTPORTin`, the block captures the 32-bit `busMuxOut` value (the value OUTPORT itself latches) into a small FIFO. It then serialises the captured bytes, least-significant byte first, as 8N1 UART frames on `txd`. Status flags let the test program or board logic detect back-pressure and lost words.

---
 rtl/outport_pkg.sv | 20 ++
 rtl/outport_fifo.sv | 74 +++++++
 rtl/outport_uart_tx.sv | 176 +++++++++++++++++
 tb/tb_outport_uart_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/outport_pkg.sv
// Shared types and constants for the OUTPORT UART transmitter.
// Frame geometry is 8N1: one start bit, eight data bits, one stop bit.
package outport_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Bring the next byte of a captured word down into bits [7:0].
  function automatic logic [31:0] next_byte_word(input logic [31:0] w);
    return {8'h00, w[31:8]};
  endfunction

endpackage

// File: rtl/outport_fifo.sv
// Synchronous FIFO holding captured OUTPORT words until the transmitter takes them.
// A push while full is accepted only if a pop happens on the same edge.
module outport_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [LVL_W-1:0] PTR_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_EMPTY = LVL_W'(0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0] wr_q, wr_d;
  logic [LVL_W-1:0] rd_q, rd_d;
  logic [LVL_W-1:0] level_s;
  logic             full_s, empty_s;
  logic             push_ok_s, pop_ok_s;

  assign level_s = wr_q - rd_q;
  assign full_s  = (level_s == LVL_FULL);
  assign empty_s = (level_s == LVL_EMPTY);

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_comb begin
    pop_ok_s  = pop & ~empty_s;
    push_ok_s = push & (~full_s | pop_ok_s);
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (push_ok_s) begin
      wr_d = wr_q + PTR_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok_s) begin
      rd_d = rd_q + PTR_ONE;
    end else begin
      rd_d = rd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= LVL_W'(0);
      rd_q <= LVL_W'(0);
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

  assign dout  = mem_q[rd_q[AW-1:0]];
  assign full  = full_s;
  assign empty = empty_s;
  assign level = level_s;

endmodule

// File: rtl/outport_uart_tx.sv
// Captures OUTPORT bus words into a FIFO and sends their low SEND_BYTES bytes,
// least-significant byte first, as back-to-back 8N1 UART frames on txd.
module outport_uart_tx
  import outport_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SEND_BYTES   = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          OUTPORTin,
  input  logic [31:0]                   busMuxOut,
  output logic                          txd,
  output logic                          busy,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [1:0]        BYTE_LAST = 2'(SEND_BYTES - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              overflow_q, overflow_d;

  logic              pop_s;
  logic              bit_end_s;
  logic [2:0]        bit_next_s;
  logic [7:0]        cur_byte_s;
  logic [31:0]       fifo_head_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [LVL_W-1:0]  fifo_level_s;

  outport_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (OUTPORTin),
    .pop   (pop_s),
    .din   (busMuxOut),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

  assign bit_end_s  = (baud_q == BAUD_LAST);
  assign bit_next_s = bit_q + 3'd1;
  assign cur_byte_s = shift_q[7:0];

  // txd_d is the line value for the state being entered, so txd stays a pure flop.
  always_comb begin
    state_d = state_q;
    baud_d  = BAUD_ZERO;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop_s   = 1'b0;

    if (state_q == ST_IDLE) begin
      baud_d = BAUD_ZERO;
    end else if (bit_end_s) begin
      baud_d = BAUD_ZERO;
    end else begin
      baud_d = baud_q + BAUD_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_head_s;
          byte_d  = 2'd0;
          state_d = ST_START;
          txd_d   = 1'b0;
        end else begin
          txd_d   = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          txd_d   = cur_byte_s[0];
        end else begin
          txd_d   = 1'b0;
        end
      end
      ST_DATA: begin
        if (!bit_end_s) begin
          txd_d   = cur_byte_s[bit_q];
        end else if (bit_q == BIT_LAST) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end else begin
          bit_d   = bit_next_s;
          txd_d   = cur_byte_s[bit_next_s];
        end
      end
      ST_STOP: begin
        // Next byte of this word first, then the next queued word with no idle gap.
        if (!bit_end_s) begin
          txd_d   = 1'b1;
        end else if (byte_q != BYTE_LAST) begin
          shift_d = next_byte_word(shift_q);
          byte_d  = byte_q + 2'd1;
          state_d = ST_START;
          txd_d   = 1'b0;
        end else if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_head_s;
          byte_d  = 2'd0;
          state_d = ST_START;
          txd_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // A push is dropped only when the FIFO is full and nothing leaves on the same edge.
  always_comb begin
    if (OUTPORTin && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= BAUD_ZERO;
      bit_q      <= 3'd0;
      byte_q     <= 2'd0;
      shift_q    <= 32'h0000_0000;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

  assign txd      = txd_q;
  assign busy     = (state_q != ST_IDLE) | (fifo_level_s != LVL_W'(0));
  assign full     = fifo_full_s;
  assign overflow = overflow_q;
  assign level    = fifo_level_s;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx with CLKS_PER_BIT=4: one instance sending
// one byte per word (FIFO and reset scenarios) and one sending four bytes per word.
module tb_outport_uart_tx;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        out1, out4;
  logic [31:0] bus;

  logic        txd1, busy1, full1, ovf1;
  logic [2:0]  level1;
  logic        txd4, busy4, full4, ovf4;
  logic [2:0]  level4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0]  line_a5;
  logic [9:0]  line_5a;
  logic [31:0] word4;
  logic [31:0] wq [7];

  outport_uart_tx #(.CLKS_PER_BIT(4), .SEND_BYTES(1), .FIFO_DEPTH(4)) u1 (
    .Clock(Clock), .Reset(Reset), .OUTPORTin(out1), .busMuxOut(bus),
    .txd(txd1), .busy(busy1), .full(full1), .overflow(ovf1), .level(level1)
  );

  outport_uart_tx #(.CLKS_PER_BIT(4), .SEND_BYTES(4), .FIFO_DEPTH(4)) u4 (
    .Clock(Clock), .Reset(Reset), .OUTPORTin(out4), .busMuxOut(bus),
    .txd(txd4), .busy(busy4), .full(full4), .overflow(ovf4), .level(level4)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Line level at position pos (0=start, 1..8 data LSB first, 9=stop) of an 8N1 frame.
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    else if (pos == 9) return 1'b1;
    else return b[pos-1];
  endfunction

  initial begin
    line_a5 = 10'b11_0100_1010;   // read bit 0 first: 0,1,0,1,0,0,1,0,1,1
    line_5a = 10'b10_1011_0100;   // read bit 0 first: 0,0,1,0,1,1,0,1,0,1
    word4   = 32'h1122_3344;
    wq[0] = 32'hDEAD_BEC3; wq[1] = 32'h1234_5696; wq[2] = 32'h0000_003C;
    wq[3] = 32'hFFFF_FFE1; wq[4] = 32'hABCD_EF0F; wq[5] = 32'h0101_016B;
    wq[6] = 32'h7777_7755;

    Reset = 1'b1; out1 = 1'b0; out4 = 1'b0; bus = 32'h0;
    repeat (2) tick;
    check("rst_txd",   32'(txd1),   32'd1);
    check("rst_busy",  32'(busy1),  32'd0);
    check("rst_level", 32'(level1), 32'd0);
    check("rst_ovf",   32'(ovf1),   32'd0);
    check("rst_full",  32'(full1),  32'd0);
    check("rst_txd4",  32'(txd4),   32'd1);
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      check("idle_txd", 32'(txd1), 32'd1);
    end

    // Single byte 0xA5
    bus = 32'h0000_00A5; out1 = 1'b1;
    tick;
    out1 = 1'b0; bus = 32'h0;
    check("a5_level_cap", 32'(level1), 32'd1);
    check("a5_txd_cap",   32'(txd1),   32'd1);
    tick;
    check("a5_level_pop", 32'(level1), 32'd0);
    check("a5_busy",      32'(busy1),  32'd1);
    for (int i = 0; i < 10; i++) begin
      check("a5_line", 32'(txd1), 32'(line_a5[i]));
      if (i < 9) repeat (4) tick;
    end
    repeat (3) tick;
    check("a5_busy_end-1", 32'(busy1), 32'd1);
    tick;
    check("a5_busy_end", 32'(busy1), 32'd0);
    check("a5_txd_end",  32'(txd1),  32'd1);

    // Four bytes of 0x11223344, checked every cycle for gapless frames
    bus = word4; out4 = 1'b1;
    tick;
    out4 = 1'b0; bus = 32'h0;
    check("w4_level_cap", 32'(level4), 32'd1);
    tick;
    for (int i = 0; i < 160; i++) begin
      check("w4_line", 32'(txd4), 32'(frame_bit(word4[8*(i/40) +: 8], (i % 40) / 4)));
      tick;
    end
    check("w4_busy_end", 32'(busy4), 32'd0);
    check("w4_txd_end",  32'(txd4),  32'd1);

    // Fill FIFO, push on the pop edge, then overflow with a dropped word
    for (int n = 1; n <= 241; n++) begin
      out1 = 1'b0; bus = 32'h0;
      if (n <= 5) begin
        out1 = 1'b1; bus = wq[n-1];
      end else if (n == 42) begin
        out1 = 1'b1; bus = wq[5];
      end else if (n == 43) begin
        out1 = 1'b1; bus = wq[6];
      end
      tick;
      if (n >= 2)
        check("fifo_line", 32'(txd1), 32'(frame_bit(wq[(n-2)/40][7:0], ((n-2) % 40) / 4)));
      if (n == 1) check("fifo_level1", 32'(level1), 32'd1);
      if (n == 5) begin
        check("fifo_level4", 32'(level1), 32'd4);
        check("fifo_full",   32'(full1),  32'd1);
        check("fifo_noovf",  32'(ovf1),   32'd0);
      end
      if (n == 42) begin
        check("pushpop_level", 32'(level1), 32'd4);
        check("pushpop_ovf",   32'(ovf1),   32'd0);
      end
      if (n == 43) begin
        check("drop_ovf",   32'(ovf1),   32'd1);
        check("drop_level", 32'(level1), 32'd4);
      end
      if (n == 82) check("pop_level3", 32'(level1), 32'd3);
    end
    out1 = 1'b0; bus = 32'h0;
    tick;
    check("fifo_busy_end",  32'(busy1),  32'd0);
    check("fifo_level_end", 32'(level1), 32'd0);
    check("fifo_txd_end",   32'(txd1),   32'd1);
    check("fifo_ovf_stick", 32'(ovf1),   32'd1);

    // Reset in DATA bit 3 with one word still queued
    bus = 32'h0000_00F0; out1 = 1'b1;
    tick;
    bus = 32'h0000_0077;
    tick;
    out1 = 1'b0; bus = 32'h0;
    repeat (17) tick;
    check("pre_rst_txd",   32'(txd1),   32'd0);
    check("pre_rst_level", 32'(level1), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_txd",   32'(txd1),   32'd1);
    check("async_rst_level", 32'(level1), 32'd0);
    check("async_rst_busy",  32'(busy1),  32'd0);
    check("async_rst_ovf",   32'(ovf1),   32'd0);
    tick;
    Reset = 1'b0;
    bus = 32'h0000_005A; out1 = 1'b1;
    tick;
    out1 = 1'b0; bus = 32'h0;
    tick;
    for (int i = 0; i < 10; i++) begin
      check("5a_line", 32'(txd1), 32'(line_5a[i]));
      if (i < 9) repeat (4) tick;
    end
    repeat (4) tick;
    check("5a_busy_end", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
